// File: rtl/rst_sequencer_if.sv
// rtl/rst_sequencer_if.sv - request/status bundle between the reset sequencer and its controller
interface rst_sequencer_if;
  logic sw_rst_req;
  logic bus_idle;
  logic fabric_rst_n;
  logic slave_rst_n;
  logic master_rst_n;
  logic rst_done;
  logic sw_rst_ack;
  logic drain_timeout;

  modport master (
    output sw_rst_req,
    output bus_idle,
    input  fabric_rst_n,
    input  slave_rst_n,
    input  master_rst_n,
    input  rst_done,
    input  sw_rst_ack,
    input  drain_timeout
  );

  modport slave (
    input  sw_rst_req,
    input  bus_idle,
    output fabric_rst_n,
    output slave_rst_n,
    output master_rst_n,
    output rst_done,
    output sw_rst_ack,
    output drain_timeout
  );
endinterface

// File: rtl/rst_sequencer.sv
// rtl/rst_sequencer.sv - staged fabric/slave/master reset release with drained software reset
module rst_sequencer #(
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter int SOFT_RST_CYCLES = 8,
  parameter int DRAIN_TIMEOUT   = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  rst_sequencer_if.slave bus
);

  localparam int MAX_AB = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int MAX_CD = (SOFT_RST_CYCLES > DRAIN_TIMEOUT) ? SOFT_RST_CYCLES : DRAIN_TIMEOUT;
  localparam int MAX_N  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = $clog2(MAX_N) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STAGE_GAP - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST  = CNT_W'(SOFT_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_HOLD, S_REL_FABRIC, S_REL_SLAVE, S_RUN, S_DRAIN, S_SOFT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             fabric_q, fabric_d;
  logic             slave_q, slave_d;
  logic             master_q, master_d;
  logic             done_q, done_d;
  logic             ack_q, ack_d;
  logic             tmo_q, tmo_d;
  logic             from_soft_q, from_soft_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      fabric_q    <= 1'b0;
      slave_q     <= 1'b0;
      master_q    <= 1'b0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      tmo_q       <= 1'b0;
      from_soft_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fabric_q    <= fabric_d;
      slave_q     <= slave_d;
      master_q    <= master_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      tmo_q       <= tmo_d;
      from_soft_q <= from_soft_d;
      // Restart timing on every state change; otherwise count up and stick at all-ones.
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    fabric_d    = fabric_q;
    slave_d     = slave_q;
    master_d    = master_q;
    done_d      = done_q;
    ack_d       = 1'b0;
    tmo_d       = tmo_q;
    from_soft_d = from_soft_q;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d  = S_REL_FABRIC;
          fabric_d = 1'b1;
        end
      end
      S_REL_FABRIC: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_REL_SLAVE;
          slave_d = 1'b1;
        end
      end
      S_REL_SLAVE: begin
        if (cnt_q == GAP_LAST) begin
          state_d     = S_RUN;
          master_d    = 1'b1;
          done_d      = 1'b1;
          ack_d       = from_soft_q;
          from_soft_d = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.sw_rst_req) begin
          state_d = S_DRAIN;
          done_d  = 1'b0;
        end
      end
      S_DRAIN: begin
        // Bus idle wins over a coincident timeout so the flag only marks a forced cut.
        if (bus.bus_idle || cnt_q == DRAIN_LAST) begin
          state_d     = S_SOFT;
          fabric_d    = 1'b0;
          slave_d     = 1'b0;
          master_d    = 1'b0;
          from_soft_d = 1'b1;
          if (!bus.bus_idle) tmo_d = 1'b1;
        end
      end
      S_SOFT: begin
        if (cnt_q == SOFT_LAST) begin
          state_d  = S_REL_FABRIC;
          fabric_d = 1'b1;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  assign bus.fabric_rst_n  = fabric_q;
  assign bus.slave_rst_n   = slave_q;
  assign bus.master_rst_n  = master_q;
  assign bus.rst_done      = done_q;
  assign bus.sw_rst_ack    = ack_q;
  assign bus.drain_timeout = tmo_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// tb/tb_rst_sequencer.sv - scoreboard bench for rst_sequencer output change events
module tb_rst_sequencer;

  typedef struct {
    int         edge_n;
    logic [5:0] vec;
  } exp_t;

  logic clk;
  logic rst_n;
  int   edge_cnt;
  int   n_checks;
  int   n_pass;
  exp_t exp_q[$];
  exp_t got_e;
  logic [5:0] cur_vec;
  logic [5:0] prev_vec;

  rst_sequencer_if bus ();

  rst_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  // Vector order: fabric, slave, master, rst_done, ack, drain_timeout
  function automatic logic [5:0] out_vec();
    return {bus.fabric_rst_n, bus.slave_rst_n, bus.master_rst_n,
            bus.rst_done, bus.sw_rst_ack, bus.drain_timeout};
  endfunction

  always @(negedge clk) begin
    cur_vec = out_vec();
    if (!rst_n) begin
      prev_vec = 6'b0;
    end else if (cur_vec !== prev_vec) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change edge=%0d got=%b required=no change", edge_cnt, cur_vec);
      end else begin
        got_e = exp_q.pop_front();
        if (got_e.edge_n == edge_cnt && got_e.vec === cur_vec)
          n_pass++;
        else
          $display("FAIL event got edge=%0d vec=%b required edge=%0d vec=%b",
                   edge_cnt, cur_vec, got_e.edge_n, got_e.vec);
      end
      prev_vec = cur_vec;
    end
  end

  task automatic expect_ev(input int e, input logic [5:0] v);
    exp_t x;
    x.edge_n = e;
    x.vec    = v;
    exp_q.push_back(x);
  endtask

  task automatic check_vec(input string name, input logic [5:0] req);
    logic [5:0] v;
    v = out_vec();
    n_checks++;
    if (v === req) n_pass++;
    else $display("FAIL %s got=%b required=%b", name, v, req);
  endtask

  task automatic wait_edge(input int n);
    int guard;
    guard = 0;
    while (edge_cnt < n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (edge_cnt < n) begin
      n_checks++;
      $display("FAIL wait_edge got=%0d required=%0d", edge_cnt, n);
    end
  endtask

  task automatic pulse_req(input int a);
    wait_edge(a - 1);
    bus.sw_rst_req = 1'b1;
    @(posedge clk);
    #1;
    bus.sw_rst_req = 1'b0;
  endtask

  task automatic apply_reset(input string name);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_vec(name, 6'b000000);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic expect_powerup();
    expect_ev(16, 6'b100000);
    expect_ev(20, 6'b110000);
    expect_ev(24, 6'b111100);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    prev_vec = 6'b0;
    rst_n    = 1'b0;
    bus.sw_rst_req = 1'b0;
    bus.bus_idle   = 1'b1;

    apply_reset("reset_state");
    expect_powerup();
    pulse_req(10);

    expect_ev(100, 6'b111000);
    expect_ev(101, 6'b000000);
    expect_ev(109, 6'b100000);
    expect_ev(113, 6'b110000);
    expect_ev(117, 6'b111110);
    expect_ev(118, 6'b111100);
    pulse_req(100);
    pulse_req(105);

    wait_edge(195);
    bus.bus_idle = 1'b0;
    expect_ev(200, 6'b111000);
    expect_ev(210, 6'b000000);
    expect_ev(218, 6'b100000);
    expect_ev(222, 6'b110000);
    expect_ev(226, 6'b111110);
    expect_ev(227, 6'b111100);
    pulse_req(200);
    wait_edge(209);
    bus.bus_idle = 1'b1;

    wait_edge(290);
    bus.bus_idle = 1'b0;
    expect_ev(300, 6'b111000);
    expect_ev(364, 6'b000001);
    expect_ev(372, 6'b100001);
    expect_ev(376, 6'b110001);
    expect_ev(380, 6'b111111);
    expect_ev(381, 6'b111101);
    pulse_req(300);
    wait_edge(400);
    check_vec("timeout_sticky", 6'b111101);

    expect_ev(420, 6'b111001);
    pulse_req(420);
    wait_edge(425);
    apply_reset("async_in_drain");
    bus.bus_idle = 1'b1;
    expect_powerup();
    wait_edge(30);

    apply_reset("async_in_run");
    expect_ev(16, 6'b100000);
    expect_ev(20, 6'b110000);
    wait_edge(21);
    apply_reset("async_in_rel_slave");
    expect_powerup();
    wait_edge(30);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL pending_events got=%0d required=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
